encoder_decoder_2to4_seq: RTL and testbench
===========================================

ENCODER_DECODER_2TO4_SEQ -- requirements
Module: decoder2to4_seq

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, sets the number of clock cycles a one-hot output is driven (legal range 1..255).
REQ-002 Parameter GAP_CYCLES, default 1, sets the number of idle cycles forced after each drive (legal range 0..255).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 a1  input  1  code MSB (same bit order as the 4-to-2 encoder outputs a1,a0).
REQ-006 a0  input  1  code LSB.
REQ-007 in_valid  input  1  code on a1,a0 is valid this cycle.
REQ-008 in_ready  output  1  block can accept a code this cycle.
REQ-009 y3,y2,y1,y0  output  1 each  registered one-hot decoded lines, y0 for code 00 through y3 for code 11.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle pulse marking the end of a drive interval.

Function
REQ-012 The FSM SHALL have three states: IDLE, DRIVE and GAP.
REQ-013 in_ready SHALL be 1 only in IDLE; acceptance occurs on a rising edge where in_valid=1 and in_ready=1.
REQ-014 On acceptance the FSM SHALL latch {a1,a0}, enter DRIVE, load an 8-bit down-counter with HOLD_CYCLES-1, and drive exactly one y line high from the next cycle (latency 1).
REQ-015 In DRIVE, y SHALL stay constant for exactly HOLD_CYCLES cycles; a1, a0 and in_valid SHALL be ignored.
REQ-016 When the counter reaches 0 in DRIVE, all y lines SHALL go to 0 on the next edge, and done SHALL be 1 for that one cycle.
REQ-017 On that same edge the FSM SHALL enter GAP with the counter loaded to GAP_CYCLES-1, or enter IDLE directly if GAP_CYCLES=0.
REQ-018 GAP SHALL last exactly GAP_CYCLES cycles with y=0, then return to IDLE.
REQ-019 With GAP_CYCLES=0, a code presented on the done cycle SHALL be accepted, so back-to-back drives are separated by exactly one cycle with y=0.
REQ-020 At most one y line SHALL ever be high; y SHALL be 0000 in IDLE and GAP.
REQ-021 busy SHALL equal (state != IDLE); done SHALL never be high in two consecutive cycles.

Reset
REQ-022 rst_n=0 SHALL asynchronously force state=IDLE, counter=0, latched code=00, y3..y0=0, done=0 and busy=0; in_ready SHALL read 0 while rst_n=0.
REQ-023 Reset asserted mid-DRIVE or mid-GAP SHALL abort the operation without a done pulse.
REQ-024 After rst_n deasserts, the first rising edge SHALL be able to accept a code.

Configuration
REQ-025 When macro DEC_PARITY_EN is defined, the block SHALL add input par (1 bit, even parity over a1,a0,par) and output perr (1 bit).
REQ-026 With DEC_PARITY_EN, an accepted code with odd parity SHALL be dropped: the FSM stays in IDLE, y stays 0000, and perr pulses high for one cycle.
REQ-027 Without DEC_PARITY_EN, par and perr SHALL not exist, and every accepted code SHALL be decoded.

Verification
REQ-028 Defaults; apply codes 00, 01, 10, 11 in turn, each for one cycle with in_valid -> y0, y1, y2, y3 high in turn for 4 cycles each; done pulses after each; in_ready=0 for 5 cycles per code.
REQ-029 In DRIVE with code 10, toggle a1,a0 and in_valid every cycle -> y2 held steady for all 4 cycles; no second acceptance.
REQ-030 GAP_CYCLES=0, HOLD_CYCLES=1, hold in_valid=1 with code 11 -> y3 pattern 1,0,1,0... and done on every y=0 cycle.
REQ-031 Pull rst_n low in the 2nd cycle of DRIVE with code 01 -> y1 drops immediately with no done pulse; after release a code 00 is accepted on the first edge.
REQ-032 DEC_PARITY_EN defined; code 01 with par=0 -> perr pulses once and y stays 0000; code 01 with par=1 -> y1 driven normally.

Source files
------------

// File: rtl/encoder_decoder_2to4_seq.sv
// Purpose: sequential 2-to-4 decoder; an accepted code drives one registered one-hot line for HOLD_CYCLES, then idles GAP_CYCLES.
// Latency: 1 cycle from the accepting edge to the one-hot output.
// Backpressure: in_ready is high only in IDLE. Optional parity check is built when DEC_PARITY_EN is defined.
module encoder_decoder_2to4_seq #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a1,
    input  logic a0,
    input  logic in_valid,
`ifdef DEC_PARITY_EN
    input  logic par,
    output logic perr,
`endif
    output logic in_ready,
    output logic y3,
    output logic y2,
    output logic y1,
    output logic y0,
    output logic busy,
    output logic done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Counter reload values; the gap reload is unused when there is no gap.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] code_q, code_d;
    logic [3:0] y_q, y_d;
    logic       done_q, done_d;
    logic       accept;
    logic       code_ok;
`ifdef DEC_PARITY_EN
    logic       perr_q, perr_d;
`endif

    // in_ready is masked by reset so nothing looks acceptable while held in reset.
    assign in_ready = (state_q == ST_IDLE) && rst_n;
    assign accept   = in_valid && in_ready;

`ifdef DEC_PARITY_EN
    // Even parity over {a1, a0, par}; an odd-parity code is dropped.
    assign code_ok = ~(a1 ^ a0 ^ par);
`else
    assign code_ok = 1'b1;
`endif

    // Next-state and next-output logic; every target gets its hold value first.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        done_d  = 1'b0;
`ifdef DEC_PARITY_EN
        perr_d  = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (code_ok) begin
                        state_d = ST_DRIVE;
                        cnt_d   = HOLD_LOAD;
                        code_d  = {a1, a0};
                    end
`ifdef DEC_PARITY_EN
                    else begin
                        perr_d = 1'b1;
                    end
`endif
                end
            end
            ST_DRIVE: begin
                // Inputs are ignored here; only the counter decides when the drive ends.
                if (cnt_q == 8'd0) begin
                    done_d = 1'b1;
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        // One-hot line follows the latched code only while driving.
        y_d = (state_d == ST_DRIVE) ? (4'b0001 << code_d) : 4'b0000;
    end

    // State and output registers; reset aborts any operation without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            code_q  <= 2'b00;
            y_q     <= 4'b0000;
            done_q  <= 1'b0;
`ifdef DEC_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            y_q     <= y_d;
            done_q  <= done_d;
`ifdef DEC_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign {y3, y2, y1, y0} = y_q;
    assign busy             = (state_q != ST_IDLE);
    assign done             = done_q;
`ifdef DEC_PARITY_EN
    assign perr             = perr_q;
`endif

endmodule

// File: tb/tb_encoder_decoder_2to4_seq.sv
// Bench for encoder_decoder_2to4_seq: DUT A uses default timing, DUT B uses HOLD=1/GAP=0.
// A schedule-based model predicts every output each cycle; directed steps add literal checks.
// Parity stimulus is included when DEC_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_encoder_decoder_2to4_seq;

    localparam int HOLD_A = 4;
    localparam int GAP_A  = 1;
    localparam int HOLD_B = 1;
    localparam int GAP_B  = 0;

    typedef struct packed {
        logic [3:0] y;
        logic       busy;
        logic       done;
        logic       rdy;
        logic       perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a1_a = 1'b0, a0_a = 1'b0, vld_a = 1'b0;
    logic       a1_b = 1'b0, a0_b = 1'b0, vld_b = 1'b0;
    logic       rdy_a, busy_a, done_a, rdy_b, busy_b, done_b;
    logic [3:0] y_a, y_b;
`ifdef DEC_PARITY_EN
    logic       par_a = 1'b0;
    logic       par_b, perr_a, perr_b;
    assign par_b = a1_b ^ a0_b;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    logic [3:0] onehot_tbl [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    always #5 clk = ~clk;

    encoder_decoder_2to4_seq #(.HOLD_CYCLES(HOLD_A), .GAP_CYCLES(GAP_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .a1(a1_a), .a0(a0_a), .in_valid(vld_a),
`ifdef DEC_PARITY_EN
        .par(par_a), .perr(perr_a),
`endif
        .in_ready(rdy_a), .y3(y_a[3]), .y2(y_a[2]), .y1(y_a[1]), .y0(y_a[0]),
        .busy(busy_a), .done(done_a)
    );

    encoder_decoder_2to4_seq #(.HOLD_CYCLES(HOLD_B), .GAP_CYCLES(GAP_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .a1(a1_b), .a0(a0_b), .in_valid(vld_b),
`ifdef DEC_PARITY_EN
        .par(par_b), .perr(perr_b),
`endif
        .in_ready(rdy_b), .y3(y_b[3]), .y2(y_b[2]), .y1(y_b[1]), .y0(y_b[0]),
        .busy(busy_b), .done(done_b)
    );

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e      = '0;
        e.rdy  = 1'b1;
        return e;
    endfunction

    // Expected outputs for the current cycle: reset values, the head of the schedule, or idle.
    function automatic exp_t head(input int w);
        if (!rst_n) return '0;
        if (w == 0) return (q_a.size() != 0) ? q_a[0] : idle_exp();
        return (q_b.size() != 0) ? q_b[0] : idle_exp();
    endfunction

    task automatic push(input int w, input exp_t e);
        if (w == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    // Append the whole cycle-by-cycle picture of one accepted code.
    task automatic sched(input int w, input int hold, input int gap, input logic [1:0] code, input logic bad);
        exp_t e;
        if (bad) begin
            e      = idle_exp();
            e.perr = 1'b1;
            push(w, e);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            e      = '0;
            e.y    = 4'b0001 << code;
            e.busy = 1'b1;
            push(w, e);
        end
        e      = '0;
        e.done = 1'b1;
        e.busy = (gap > 0);
        e.rdy  = (gap == 0);
        push(w, e);
        for (int i = 1; i < gap; i++) begin
            e      = '0;
            e.busy = 1'b1;
            push(w, e);
        end
    endtask

    function automatic logic bad_par_a();
`ifdef DEC_PARITY_EN
        return a1_a ^ a0_a ^ par_a;
`else
        return 1'b0;
`endif
    endfunction

    // Model advance: consume this cycle's expectation and schedule any accepted code.
    always @(posedge clk or negedge rst_n) begin : model
        exp_t ca, cb;
        if (!rst_n) begin
            q_a.delete();
            q_b.delete();
        end else begin
            ca = head(0);
            cb = head(1);
            if (q_a.size() != 0) void'(q_a.pop_front());
            if (q_b.size() != 0) void'(q_b.pop_front());
            if (ca.rdy && vld_a) sched(0, HOLD_A, GAP_A, {a1_a, a0_a}, bad_par_a());
            if (cb.rdy && vld_b) sched(1, HOLD_B, GAP_B, {a1_b, a0_b}, 1'b0);
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin : compare
        exp_t ea, eb;
        ea = head(0);
        eb = head(1);
        cmp("a_y",    int'(y_a),    int'(ea.y));
        cmp("a_busy", int'(busy_a), int'(ea.busy));
        cmp("a_done", int'(done_a), int'(ea.done));
        cmp("a_rdy",  int'(rdy_a),  int'(ea.rdy));
        cmp("b_y",    int'(y_b),    int'(eb.y));
        cmp("b_busy", int'(busy_b), int'(eb.busy));
        cmp("b_done", int'(done_b), int'(eb.done));
        cmp("b_rdy",  int'(rdy_b),  int'(eb.rdy));
`ifdef DEC_PARITY_EN
        cmp("a_perr", int'(perr_a), int'(ea.perr));
        cmp("b_perr", int'(perr_b), int'(eb.perr));
`endif
    end

    initial begin : stim
        int hi, nr, dn;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_y_a",    int'(y_a),    0);
        cmp("rst_busy_a", int'(busy_a), 0);
        cmp("rst_done_a", int'(done_a), 0);
        cmp("rst_rdy_a",  int'(rdy_a),  0);
        cmp("rst_y_b",    int'(y_b),    0);
        rst_n = 1'b1;
        #1;
        cmp("rdy_after_rst", int'(rdy_a), 1);

        // Each code in turn: 4 drive cycles, 5 not-ready cycles, one done pulse.
        for (int c = 0; c < 4; c++) begin
            {a1_a, a0_a} = 2'(c);
            vld_a = 1'b1;
            @(posedge clk); #1;
            vld_a = 1'b0;
            {a1_a, a0_a} = 2'(3 - c);
            hi = 0; nr = 0; dn = 0;
            for (int k = 0; k < 7; k++) begin
                @(negedge clk);
                if (y_a == onehot_tbl[c]) hi++;
                if (!rdy_a) nr++;
                if (done_a) dn++;
            end
            cmp("seq_hold_cycles", hi, 4);
            cmp("seq_busy_cycles", nr, 5);
            cmp("seq_done_pulses", dn, 1);
            @(posedge clk); #1;
        end

        // Code 10 with inputs thrashing during the drive and gap.
        {a1_a, a0_a} = 2'b10;
        vld_a = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            vld_a = ~vld_a;
            a1_a  = ~a1_a;
            a0_a  = ~a0_a;
            @(negedge clk);
            if (k < 4) begin
                cmp("hold_y2", int'(y_a), 4);
            end else begin
                cmp("hold_end_y",    int'(y_a),    0);
                cmp("hold_end_done", int'(done_a), 1);
            end
            @(posedge clk); #1;
        end
        vld_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cmp("no_reaccept_y",    int'(y_a),    0);
            cmp("no_reaccept_busy", int'(busy_a), 0);
            @(posedge clk); #1;
        end

        // Reset in the second drive cycle of code 01, then accept 00 on the first edge.
        {a1_a, a0_a} = 2'b01;
        vld_a = 1'b1;
        @(posedge clk); #1;
        vld_a = 1'b0;
        @(posedge clk); #1;
        cmp("drive2_y1", int'(y_a), 2);
        rst_n = 1'b0;
        #1;
        cmp("abort_y",    int'(y_a),    0);
        cmp("abort_busy", int'(busy_a), 0);
        cmp("abort_rdy",  int'(rdy_a),  0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_a) dn++;
        end
        cmp("abort_no_done", dn, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        {a1_a, a0_a} = 2'b00;
        vld_a = 1'b1;
        @(posedge clk); #1;
        vld_a = 1'b0;
        cmp("post_rst_accept_y0", int'(y_a), 1);
        repeat (6) @(posedge clk);
        #1;

        // DUT B: code 11 held valid gives 1,0,1,0 with done on every low cycle.
        {a1_b, a0_b} = 2'b11;
        vld_b = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            cmp("b2b_y3",   int'(y_b),    (k % 2 == 0) ? 8 : 0);
            cmp("b2b_done", int'(done_b), k % 2);
        end
        @(posedge clk); #1;
        vld_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;

`ifdef DEC_PARITY_EN
        // Odd parity is dropped with a perr pulse; even parity decodes normally.
        {a1_a, a0_a} = 2'b01;
        par_a = 1'b0;
        vld_a = 1'b1;
        @(posedge clk); #1;
        vld_a = 1'b0;
        cmp("perr_pulse", int'(perr_a), 1);
        cmp("perr_y",     int'(y_a),    0);
        @(posedge clk); #1;
        cmp("perr_clear", int'(perr_a), 0);
        cmp("perr_y_idle", int'(y_a),   0);
        par_a = 1'b1;
        vld_a = 1'b1;
        @(posedge clk); #1;
        vld_a = 1'b0;
        cmp("par_ok_y1", int'(y_a), 2);
        repeat (6) @(posedge clk);
        #1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
